// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared definitions for the FFT output reorder buffer: FSM encodings and bit reversal.
package fft_bitrev_reorder_pkg;

  localparam int unsigned MAX_LOG2N = 12;

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_FILL  = 1'b1;
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_DRAIN = 1'b1;

  // Reverse the low nbits bits of value; bits above nbits come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                  input int nbits);
    logic [MAX_LOG2N-1:0] v;
    logic [MAX_LOG2N-1:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < int'(MAX_LOG2N); i++) begin
      if (i < nbits) begin
        r = {r[MAX_LOG2N-2:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: one write port, one registered read port, bank select on each.
module fft_pingpong_ram #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 * (2 ** AW);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, waddr}] <= wdata;
  end

  // Output register reads as zero whenever no read was issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata_q <= '0;
    else if (re) rdata_q <= mem[{rbank, raddr}];
    else         rdata_q <= '0;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes a bit-reversed FFT frame, replays it in natural order.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int unsigned INTEGER_SIZE = 16,
  parameter int unsigned FRACT_SIZE   = 16,
  parameter int unsigned NFFT         = 128
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic                                in_start,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]  in_r,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]  in_i,
  input  logic                                bypass,
  output logic                                out_valid,
  output logic                                out_start,
  output logic                                out_end,
  output logic [INTEGER_SIZE+FRACT_SIZE-1:0]  out_r,
  output logic [INTEGER_SIZE+FRACT_SIZE-1:0]  out_i,
  output logic                                frame_err,
  output logic                                busy
);

  localparam int unsigned DATA_WIDTH = INTEGER_SIZE + FRACT_SIZE;
  localparam int unsigned LOG2N      = $clog2(NFFT);
  localparam logic [LOG2N-1:0] LAST  = LOG2N'(NFFT - 1);

  logic [0:0]       wstate_q, wstate_d;
  logic [0:0]       rstate_q, rstate_d;
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [1:0]       full_q, full_d;
  logic [1:0]       byp_q, byp_d;
  logic             frame_err_q, frame_err_d;
  logic             out_valid_q, out_valid_d;
  logic             out_start_q, out_start_d;
  logic             out_end_q, out_end_d;
  logic             busy_q, busy_d;

  logic             we_c;
  logic [LOG2N-1:0] waddr_c;
  logic             re_c;
  logic [LOG2N-1:0] raddr_c;
  logic [2*DATA_WIDTH-1:0] rdata;

  always_comb begin
    wstate_d    = wstate_q;
    rstate_d    = rstate_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    full_d      = full_q;
    byp_d       = byp_q;
    frame_err_d = 1'b0;
    out_valid_d = 1'b0;
    out_start_d = 1'b0;
    out_end_d   = 1'b0;
    we_c        = 1'b0;
    waddr_c     = '0;
    re_c        = 1'b0;
    raddr_c     = '0;

    // Read side first so a completing write into the other bank is not overridden.
    case (rstate_q)
      R_IDLE: begin
        if (full_q[rbank_q]) begin
          rstate_d = R_DRAIN;
          rcnt_d   = '0;
        end
      end
      R_DRAIN: begin
        re_c        = 1'b1;
        raddr_c     = byp_q[rbank_q] ? rcnt_q
                                     : LOG2N'(bitrev(MAX_LOG2N'(rcnt_q), int'(LOG2N)));
        out_valid_d = 1'b1;
        out_start_d = (rcnt_q == '0);
        out_end_d   = (rcnt_q == LAST);
        if (rcnt_q == LAST) begin
          full_d[rbank_q] = 1'b0;
          rbank_d         = ~rbank_q;
          rcnt_d          = '0;
          rstate_d        = full_q[~rbank_q] ? R_DRAIN : R_IDLE;
        end else begin
          rcnt_d = rcnt_q + LOG2N'(1);
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    case (wstate_q)
      W_IDLE: begin
        if (in_valid && in_start) begin
          we_c           = 1'b1;
          byp_d[wbank_q] = bypass;
          wcnt_d         = LOG2N'(1);
          wstate_d       = W_FILL;
        end
      end
      W_FILL: begin
        if (in_valid && in_start) begin
          // Restart: drop the partial frame and refill the same bank from address 0.
          we_c           = 1'b1;
          byp_d[wbank_q] = bypass;
          wcnt_d         = LOG2N'(1);
          frame_err_d    = 1'b1;
        end else if (in_valid) begin
          we_c    = 1'b1;
          waddr_c = wcnt_q;
          if (wcnt_q == LAST) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
            wcnt_d          = '0;
            wstate_d        = W_IDLE;
          end else begin
            wcnt_d = wcnt_q + LOG2N'(1);
          end
        end
      end
      default: wstate_d = W_IDLE;
    endcase

    busy_d = (wstate_d != W_IDLE) | (|full_d) | out_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate_q    <= W_IDLE;
      rstate_q    <= R_IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      full_q      <= '0;
      byp_q       <= '0;
      frame_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_end_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      rstate_q    <= rstate_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      full_q      <= full_d;
      byp_q       <= byp_d;
      frame_err_q <= frame_err_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_end_q   <= out_end_d;
      busy_q      <= busy_d;
    end
  end

  fft_pingpong_ram #(
    .DW (2 * DATA_WIDTH),
    .AW (LOG2N)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we_c),
    .wbank (wbank_q),
    .waddr (waddr_c),
    .wdata ({in_r, in_i}),
    .re    (re_c),
    .rbank (rbank_q),
    .raddr (raddr_c),
    .rdata (rdata)
  );

  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_end   = out_end_q;
  assign out_r     = rdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign out_i     = rdata[DATA_WIDTH-1:0];
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the reorder buffer at NFFT=8: ordering, bypass, back-to-back, restart, gaps, reset.
module tb_fft_bitrev_reorder;

  localparam int unsigned DW = 32;

  typedef struct packed {
    logic            byp;
    logic [7:0][7:0] in_v;
    logic [7:0][7:0] exp_v;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_start = 1'b0;
  logic [DW-1:0] in_r = '0;
  logic [DW-1:0] in_i = '0;
  logic          bypass = 1'b0;
  logic          out_valid, out_start, out_end, frame_err, busy;
  logic [DW-1:0] out_r, out_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int out_count = 0;
  int err_count = 0;
  int last_cyc = 0;
  int cap_cyc0 = 0;
  int cap_r [32];
  int cap_i [32];
  logic cap_v [32];
  logic cap_s [32];
  logic cap_e [32];
  vec_t tbl [5];

  fft_bitrev_reorder #(
    .INTEGER_SIZE (16),
    .FRACT_SIZE   (16),
    .NFFT         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_r      (in_r),
    .in_i      (in_i),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_start (out_start),
    .out_end   (out_end),
    .out_r     (out_r),
    .out_i     (out_i),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) out_count <= out_count + 1;
    if (frame_err) err_count <= err_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic s, input logic b, input int val);
    @(posedge clk);
    #1;
    in_valid = v;
    in_start = s;
    bypass   = b;
    in_r     = DW'(val);
    in_i     = DW'(-val);
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic send_frame(input logic b, input logic [7:0][7:0] vals, input logic gap);
    for (int k = 0; k < 8; k++) begin
      drv(1'b1, k == 0, (k == 0) ? b : 1'b0, int'(vals[3'(k)]));
      if (k == 7) last_cyc = cyc;
      if (gap) idle();
    end
  endtask

  task automatic capture(input int n);
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      check("capture_timeout", 0, 1);
    end else begin
      cap_cyc0 = cyc;
      for (int k = 0; k < n; k++) begin
        cap_v[5'(k)] = out_valid;
        cap_r[5'(k)] = $signed(out_r);
        cap_i[5'(k)] = $signed(out_i);
        cap_s[5'(k)] = out_start;
        cap_e[5'(k)] = out_end;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_frame(input string nm, input int off, input logic [7:0][7:0] exp);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_valid[%0d]", nm, k), int'(cap_v[5'(off + k)]), 1);
      check($sformatf("%s_r[%0d]", nm, k), cap_r[5'(off + k)], int'(exp[3'(k)]));
      check($sformatf("%s_i[%0d]", nm, k), cap_i[5'(off + k)], -int'(exp[3'(k)]));
      check($sformatf("%s_start[%0d]", nm, k), int'(cap_s[5'(off + k)]), (k == 0) ? 1 : 0);
      check($sformatf("%s_end[%0d]", nm, k), int'(cap_e[5'(off + k)]), (k == 7) ? 1 : 0);
    end
  endtask

  initial begin
    int oc0;
    int err0;
    int lc0;
    int t;

    tbl[0] = '{byp: 1'b0,
               in_v:  {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
               exp_v: {8'd7, 8'd3, 8'd5, 8'd1, 8'd6, 8'd2, 8'd4, 8'd0}};
    tbl[1] = '{byp: 1'b1,
               in_v:  {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
               exp_v: {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}};
    tbl[2] = '{byp: 1'b0,
               in_v:  {8'd27, 8'd26, 8'd25, 8'd24, 8'd23, 8'd22, 8'd21, 8'd20},
               exp_v: {8'd27, 8'd23, 8'd25, 8'd21, 8'd26, 8'd22, 8'd24, 8'd20}};
    tbl[3] = '{byp: 1'b0,
               in_v:  {8'd42, 8'd200, 8'd1, 8'd77, 8'd9, 8'd50, 8'd3, 8'd100},
               exp_v: {8'd42, 8'd9, 8'd1, 8'd3, 8'd200, 8'd50, 8'd77, 8'd100}};
    tbl[4] = '{byp: 1'b1,
               in_v:  {8'd42, 8'd200, 8'd1, 8'd77, 8'd9, 8'd50, 8'd3, 8'd100},
               exp_v: {8'd42, 8'd200, 8'd1, 8'd77, 8'd9, 8'd50, 8'd3, 8'd100}};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_r", int'(out_r), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_err", int'(frame_err), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames from the table
    for (int r = 0; r < 5; r++) begin
      err0 = err_count;
      send_frame(tbl[r].byp, tbl[r].in_v, 1'b0);
      idle();
      capture(8);
      check($sformatf("row%0d_latency", r), cap_cyc0 - last_cyc, 3);
      check_frame($sformatf("row%0d", r), 0, tbl[r].exp_v);
      repeat (4) @(negedge clk);
      check($sformatf("row%0d_no_err", r), err_count - err0, 0);
    end

    // Three frames back-to-back at full rate
    oc0 = out_count;
    lc0 = 0;
    fork
      begin
        send_frame(tbl[0].byp, tbl[0].in_v, 1'b0);
        lc0 = last_cyc;
        send_frame(tbl[1].byp, tbl[1].in_v, 1'b0);
        send_frame(tbl[2].byp, tbl[2].in_v, 1'b0);
        idle();
      end
      capture(24);
    join
    check("b2b_latency", cap_cyc0 - lc0, 3);
    check_frame("b2b_f0", 0, tbl[0].exp_v);
    check_frame("b2b_f1", 8, tbl[1].exp_v);
    check_frame("b2b_f2", 16, tbl[2].exp_v);
    repeat (10) @(negedge clk);
    check("b2b_count", out_count - oc0, 24);

    // Restart mid-frame
    oc0 = out_count;
    err0 = err_count;
    for (int k = 0; k < 5; k++) drv(1'b1, k == 0, 1'b0, k);
    check("restart_busy", int'(busy), 1);
    send_frame(1'b0, {8'd17, 8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10}, 1'b0);
    idle();
    capture(8);
    check("restart_latency", cap_cyc0 - last_cyc, 3);
    check_frame("restart", 0, {8'd17, 8'd13, 8'd15, 8'd11, 8'd16, 8'd12, 8'd14, 8'd10});
    repeat (20) @(negedge clk);
    check("restart_err_pulses", err_count - err0, 1);
    check("restart_out_count", out_count - oc0, 8);

    // Stray samples without in_start, then a half-rate frame
    oc0 = out_count;
    for (int k = 0; k < 3; k++) drv(1'b1, 1'b0, 1'b0, 99);
    idle();
    send_frame(1'b0, {8'd67, 8'd66, 8'd65, 8'd64, 8'd63, 8'd62, 8'd61, 8'd60}, 1'b1);
    capture(8);
    check("gap_latency", cap_cyc0 - last_cyc, 3);
    check_frame("gap", 0, {8'd67, 8'd63, 8'd65, 8'd61, 8'd66, 8'd62, 8'd64, 8'd60});
    repeat (10) @(negedge clk);
    check("gap_out_count", out_count - oc0, 8);
    check("gap_busy_idle", int'(busy), 0);

    // Reset during the 4th output sample
    send_frame(1'b1, tbl[1].in_v, 1'b0);
    idle();
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("midrst_found", int'(out_valid), 1);
    repeat (3) @(negedge clk);
    check("midrst_sample4", $signed(out_r), 3);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_r", int'(out_r), 0);
    check("midrst_out_i", int'(out_i), 0);
    check("midrst_out_start", int'(out_start), 0);
    check("midrst_out_end", int'(out_end), 0);
    check("midrst_busy", int'(busy), 0);
    oc0 = out_count;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_output", out_count - oc0, 0);

    // Recovery after reset
    send_frame(tbl[0].byp, tbl[0].in_v, 1'b0);
    idle();
    capture(8);
    check("recover_latency", cap_cyc0 - last_cyc, 3);
    check_frame("recover", 0, tbl[0].exp_v);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
